// File: rtl/mbist_ram.sv
// mbist_ram: single-port synchronous RAM with an integrated March C- self-test engine
module mbist_ram #(
    parameter int Adr_size  = 4,
    parameter int Dta_size  = 8,
    parameter int FAULT_EN  = 0,
    parameter int FAULT_ADR = 0,
    parameter int FAULT_BIT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic                read_en,
    input  logic [Adr_size-1:0] adress,
    input  logic [Dta_size-1:0] din,
    output logic [Dta_size-1:0] dout,
    output logic                dout_valid,
    input  logic                bist_start,
    output logic                bist_busy,
    output logic                bist_done,
    output logic                bist_fail,
    output logic [Adr_size-1:0] fail_adr,
    output logic [Dta_size-1:0] fail_data
);
    typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, M4, M5, DONE} state_t;
    localparam logic [Adr_size-1:0] LAST = '1;
    localparam logic [Adr_size-1:0] ZERO = '0;
    localparam logic [Adr_size-1:0] FADR = Adr_size'(FAULT_ADR);
    state_t state, next_state;
    logic [Adr_size-1:0] addr, next_addr, acc_adr;
    logic op, next_op, we, chk, up, idle_like, func_rd, mismatch;
    logic [Dta_size-1:0] mem [2**Adr_size];
    logic [Dta_size-1:0] rdata, fmask, expv, wdata;
    assign bist_busy = state != IDLE && state != DONE;
    assign bist_done = state == DONE;
    assign idle_like = !bist_busy;
    assign func_rd   = idle_like && read_en && !wr_en;
    assign acc_adr   = bist_busy ? addr : adress;
    always_comb begin
        fmask = '0;
        if (FAULT_EN != 0 && acc_adr == FADR) fmask[FAULT_BIT] = 1'b1;
    end
    // the stuck-at fault is modelled on the read path so every reader sees it
    assign rdata    = mem[acc_adr] & ~fmask;
    assign mismatch = chk && rdata != expv;
    always_comb begin
        next_state = state;
        next_addr  = addr;
        next_op    = op;
        we         = 1'b0;
        wdata      = din;
        chk        = 1'b0;
        expv       = '0;
        up         = state == M1 || state == M2;
        case (state)
            IDLE, DONE: begin
                we = wr_en && !read_en;
                if (bist_start) begin
                    next_state = M0;
                    next_addr  = '0;
                    next_op    = 1'b0;
                end
            end
            M0: begin
                we        = 1'b1;
                wdata     = '0;
                next_addr = addr == LAST ? '0 : addr + 1'b1;
                if (addr == LAST) next_state = M1;
            end
            M1, M2, M3, M4: begin
                expv    = (state == M2 || state == M4) ? '1 : '0;
                next_op = !op;
                if (!op) chk = 1'b1;
                else begin
                    we        = 1'b1;
                    wdata     = ~expv;
                    next_addr = up ? addr + 1'b1 : addr - 1'b1;
                    // element boundary: reload counter instead of letting it wrap
                    if (addr == (up ? LAST : ZERO)) begin
                        next_state = state == M1 ? M2 : state == M2 ? M3 : state == M3 ? M4 : M5;
                        next_addr  = state == M1 ? ZERO : LAST;
                    end
                end
            end
            M5: begin
                chk       = 1'b1;
                next_addr = addr - 1'b1;
                if (addr == ZERO) begin
                    next_state = DONE;
                    next_addr  = '0;
                end
            end
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (we) mem[acc_adr] <= wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            op         <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            bist_fail  <= 1'b0;
            fail_adr   <= '0;
            fail_data  <= '0;
        end else begin
            state      <= next_state;
            addr       <= next_addr;
            op         <= next_op;
            dout_valid <= func_rd;
            if (func_rd) dout <= rdata;
            if (idle_like && bist_start) begin
                bist_fail <= 1'b0;
                fail_adr  <= '0;
                fail_data <= '0;
            end else if (mismatch) begin
                bist_fail <= 1'b1;
                if (!bist_fail) begin
                    fail_adr  <= addr;
                    fail_data <= rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_mbist_ram.sv
// tb_mbist_ram: directed vectors for the functional port plus BIST pass, fault, lockout and reset sequences
module tb_mbist_ram;
    logic clk, rst_n, wr_en, read_en, bist_start;
    logic [3:0] adress;
    logic [7:0] din;
    logic [7:0] dout0, dout1, fdata0, fdata1;
    logic [3:0] fadr0, fadr1;
    logic valid0, valid1, busy0, busy1, done0, done1, fail0, fail1;
    int n_chk = 0, n_fail = 0;

    mbist_ram u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .read_en(read_en), .adress(adress), .din(din),
        .dout(dout0), .dout_valid(valid0), .bist_start(bist_start), .bist_busy(busy0),
        .bist_done(done0), .bist_fail(fail0), .fail_adr(fadr0), .fail_data(fdata0)
    );
    mbist_ram #(.FAULT_EN(1), .FAULT_ADR(5), .FAULT_BIT(3)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .read_en(read_en), .adress(adress), .din(din),
        .dout(dout1), .dout_valid(valid1), .bist_start(bist_start), .bist_busy(busy1),
        .bist_done(done1), .bist_fail(fail1), .fail_adr(fadr1), .fail_data(fdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [3:0] adr;
        logic [7:0] d;
        logic [7:0] e_dout;
        logic       e_valid;
    } vec_t;
    vec_t v[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a);
        read_en = 1'b1;
        wr_en   = 1'b0;
        adress  = a;
        @(negedge clk);
        read_en = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        read_en = 1'b0;
        adress  = a;
        din     = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run_bist(input bit noisy, output int cycles, output bit saw_valid);
        cycles    = 0;
        saw_valid = 1'b0;
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        while (busy0 && cycles < 1000) begin
            cycles++;
            if (noisy) begin
                wr_en      = 1'($urandom_range(1));
                read_en    = 1'($urandom_range(1));
                bist_start = 1'($urandom_range(1));
                adress     = 4'($urandom);
                din        = 8'($urandom);
            end
            @(negedge clk);
            if (valid0 || valid1) saw_valid = 1'b1;
        end
        wr_en      = 1'b0;
        read_en    = 1'b0;
        bist_start = 1'b0;
    endtask

    task automatic check_results(input string tag);
        check({tag, " done0"}, 32'(done0), 32'd1);
        check({tag, " fail0"}, 32'(fail0), 32'd0);
        check({tag, " done1"}, 32'(done1), 32'd1);
        check({tag, " fail1"}, 32'(fail1), 32'd1);
        check({tag, " fail_adr1"}, 32'(fadr1), 32'd5);
        check({tag, " fail_data1"}, 32'(fdata1), 32'hF7);
    endtask

    initial begin
        int cycles;
        bit saw;
        v[0]  = '{1'b1, 1'b0, 4'd1,  8'h10, 8'h00, 1'b0};
        v[1]  = '{1'b0, 1'b1, 4'd1,  8'h00, 8'h10, 1'b1};
        v[2]  = '{1'b0, 1'b0, 4'd1,  8'h00, 8'h10, 1'b0};
        v[3]  = '{1'b1, 1'b1, 4'd1,  8'hFF, 8'h10, 1'b0};
        v[4]  = '{1'b0, 1'b1, 4'd1,  8'h00, 8'h10, 1'b1};
        v[5]  = '{1'b1, 1'b0, 4'd2,  8'hA5, 8'h10, 1'b0};
        v[6]  = '{1'b0, 1'b1, 4'd2,  8'h00, 8'hA5, 1'b1};
        v[7]  = '{1'b1, 1'b0, 4'd15, 8'h3C, 8'hA5, 1'b0};
        v[8]  = '{1'b0, 1'b1, 4'd15, 8'h00, 8'h3C, 1'b1};
        v[9]  = '{1'b0, 1'b1, 4'd1,  8'h00, 8'h10, 1'b1};
        v[10] = '{1'b1, 1'b0, 4'd0,  8'h5A, 8'h10, 1'b0};
        v[11] = '{1'b0, 1'b1, 4'd0,  8'h00, 8'h5A, 1'b1};
        rst_n = 1'b0; wr_en = 1'b0; read_en = 1'b0; bist_start = 1'b0; adress = '0; din = '0;
        repeat (2) @(negedge clk);
        check("reset outputs", {dout0, valid0, busy0, done0, fail0, fadr0, fdata0}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            wr_en = v[i].wr; read_en = v[i].rd; adress = v[i].adr; din = v[i].d;
            @(negedge clk);
            check($sformatf("vec%0d dout", i), 32'(dout0), 32'(v[i].e_dout));
            check($sformatf("vec%0d valid", i), 32'(valid0), 32'(v[i].e_valid));
        end
        wr_en = 1'b0; read_en = 1'b0;
        @(negedge clk);
        run_bist(1'b0, cycles, saw);
        check("pass busy cycles", 32'(cycles), 32'd160);
        check_results("pass");
        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            check($sformatf("post-bist mem[%0d]", a), 32'(dout0), 32'h00);
        end
        wr(4'd3, 8'h77);
        rd(4'd3);
        check("pre-lockout dout", 32'(dout0), 32'h77);
        run_bist(1'b1, cycles, saw);
        check("lockout busy cycles", 32'(cycles), 32'd160);
        check("lockout valid", 32'(saw), 32'd0);
        check("lockout dout hold", 32'(dout0), 32'h77);
        check_results("lockout");
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        repeat (39) @(negedge clk);
        check("mid busy", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-reset outputs0", {dout0, valid0, busy0, done0, fail0, fadr0, fdata0}, '0);
        check("mid-reset outputs1", {dout1, valid1, busy1, done1, fail1, fadr1, fdata1}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_bist(1'b0, cycles, saw);
        check("restart busy cycles", 32'(cycles), 32'd160);
        check_results("restart");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mbist_ram.md
Name: mbist_ram

Overview:
- Parametrised single-port synchronous RAM with an integrated March C- memory BIST engine.
- Successor to the fixed 16x8 RAM: width and depth are configurable, and the shared bidirectional data bus is split into din/dout.
- Adds self-test with pass/fail and first-failure capture. Optional stuck-at fault injection is provided for BIST verification.
- Sits in the BIST subsystem: the CPU uses the functional port, and test control drives the bist_* port.

Parameters:
- Adr_size, 4, address width; depth N = 2**Adr_size.
- Dta_size, 8, data word width.
- FAULT_EN, 0, 1 = model a stuck-at-0 bit for verification only.
- FAULT_ADR, 0, address of the injected fault.
- FAULT_BIT, 0, bit index of the injected fault.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  functional write request.
- read_en  in  1  functional read request.
- adress  in  Adr_size  functional address.
- din  in  Dta_size  functional write data.
- dout  out  Dta_size  registered read data.
- dout_valid  out  1  one-cycle pulse when dout is updated.
- bist_start  in  1  start self-test; level, sampled on clk.
- bist_busy  out  1  BIST in progress.
- bist_done  out  1  BIST finished; sticky.
- bist_fail  out  1  at least one mismatch; sticky.
- fail_adr  out  Adr_size  address of the first mismatch.
- fail_data  out  Dta_size  data read at the first mismatch.

Behaviour:
- Reset (rst_n=0, async): dout=0, dout_valid=0, bist_busy=0, bist_done=0, bist_fail=0, fail_adr=0, fail_data=0, FSM=IDLE. The memory array is not cleared.
- Functional access, IDLE only:
  - wr_en=1, read_en=0: mem[adress]<=din at the edge.
  - read_en=1, wr_en=0: dout<=mem[adress] at the edge, dout_valid=1 for that cycle. Latency is 1 clock.
  - Both high or both low: no operation, dout holds, dout_valid=0.
- Read path under fault injection: when FAULT_EN=1, every read of FAULT_ADR (functional and BIST) returns bit FAULT_BIT forced to 0.
- Start condition: bist_start=1 sampled in IDLE or DONE clears bist_done, bist_fail, fail_adr and fail_data, then enters M0 with the address counter at 0. bist_busy=1 from the next cycle.
- While busy: functional inputs are ignored, dout holds, dout_valid=0, and bist_start is ignored.
- March C- sequence, one memory operation per clock. Background 0 = all zeros, 1 = all ones.
  - M0 up: w0.
  - M1 up: r0, w1.
  - M2 up: r1, w0.
  - M3 down: r0, w1.
  - M4 down: r1, w0.
  - M5 down: r0.
- Address counter:
  - Up elements run 0..N-1; down elements run N-1..0.
  - Two-op elements use an op toggle, read first then write, on the same address; the address advances after the write.
  - At the end of an element the counter is loaded for the next element: 0 for up, N-1 for down.
- Element end conditions use the terminal address (N-1 up, 0 down). The counter must not wrap silently.
- Total duration is exactly 10*N busy cycles (160 at defaults).
- Read compare: the read is combinational from the array in the same cycle.
  - On mismatch, bist_fail<=1.
  - If bist_fail was 0, fail_adr and fail_data are captured. Later mismatches do not overwrite them.
- Completion: the cycle after the last M5 read, bist_busy=0 and bist_done=1; FSM=DONE.
  - DONE accepts functional accesses exactly like IDLE.
  - bist_done and bist_fail hold until the next start or reset.
  - After a pass, every location contains 0.
- Reset mid-BIST returns to IDLE with all flags cleared; memory contents are undefined.
- FSM states: IDLE, M0, M1, M2, M3, M4, M5, DONE.

Test Plan:
- Write/read: write din=8'h10 to adress=1, then read adress=1. dout=8'h10 one clock after read_en, dout_valid high for 1 cycle.
- Conflict: wr_en=read_en=1 at adress=1 with din=8'hFF. No write occurs, dout holds, dout_valid=0; a later read still returns 8'h10.
- BIST pass (FAULT_EN=0): pulse bist_start.
  - bist_busy is high for exactly 160 cycles.
  - Then bist_done=1, bist_fail=0.
  - Reading all 16 addresses afterwards returns 8'h00.
- BIST fail (FAULT_EN=1, FAULT_ADR=5, FAULT_BIT=3):
  - bist_done=1, bist_fail=1.
  - fail_adr=5 and fail_data=8'hF7, the first mismatch in M2 r1.
- Reset mid-BIST: deassert rst_n 40 cycles into the test. All outputs go to 0 immediately and the FSM is IDLE; a restart runs the full 160 cycles.
- Busy lockout: toggle wr_en, read_en and bist_start during BIST. The cycle count and result are unchanged and dout_valid stays 0.
